bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares the single read/write port of the 8-bit block RAM (2048 × 8) between two requesters: the microcode CPU and the serial debug dumper. The CPU may read or write; the dumper is read-only. Arbitration is weighted: the CPU wins contested cycles, but it cannot hold the port for more than `CPU_WEIGHT` consecutive contested grants. Read data is returned one cycle after acceptance, tagged to the owning requester. The block sits between both requesters and the RAM port B pins.

## Interface
Parameters:
- `AW`, 11: address width.
- `DW`, 8: data width.
- `CPU_WEIGHT`, 4: maximum consecutive CPU grants while the dumper is waiting. Legal range is 1..15.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `RESETn`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until granted.
- `cpu_we`  in  1  1 = write, 0 = read; valid with `cpu_req`.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  combinational; CPU access accepted at this edge.
- `cpu_rvalid`  out  1  registered; `cpu_rdata` valid.
- `cpu_rdata`  out  DW  read data to CPU.
- `dbg_req`  in  1  dumper read request; held until granted.
- `dbg_addr`  in  AW  dumper address.
- `dbg_gnt`  out  1  combinational; dumper access accepted at this edge.
- `dbg_rvalid`  out  1  registered; `dbg_rdata` valid.
- `dbg_rdata`  out  DW  read data to dumper.
- `mem_ce`  out  1  RAM port enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data; synchronous, valid one cycle after address.

## Operation
- Handshake: a requester asserts `req` with stable `addr`/`we`/`wdata`. An access is accepted at the rising edge where `req && gnt`. The requester keeps `req` asserted and inputs unchanged until it sees `gnt`. It may issue a new request in the cycle after acceptance (back-to-back allowed).
- At most one grant per cycle; `cpu_gnt && dbg_gnt` is never 1.
- Mem mux (combinational):
  - On CPU grant: `mem_ce`=1, `mem_we`=`cpu_we`, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`.
  - On debug grant: `mem_ce`=1, `mem_we`=0, `mem_addr`=`dbg_addr`, `mem_wdata`=0.
  - No grant: `mem_ce`=0, `mem_we`=0, `mem_addr` and `mem_wdata` hold their last driven value. This needs a registered shadow.
- Arbitration state: `cpu_run` (4-bit counter) and `last` (1 bit: 0 = CPU, 1 = debug).
  - Only `cpu_req`: CPU granted. `cpu_run` cleared to 0, since no contest.
  - Only `dbg_req`: debug granted; `cpu_run` cleared to 0.
  - Both: debug granted if `cpu_run == CPU_WEIGHT` or `last == 1` is false while the saturation condition holds. Otherwise CPU is granted and `cpu_run` increments, saturating at `CPU_WEIGHT`. A debug grant clears `cpu_run` to 0.
  - After a contested debug grant, the next contested cycle always goes to the CPU. The dumper never wins two contested cycles in a row.
  - Neither: no grant; `cpu_run` holds.
- Read return:
  - Registered tag `rd_owner[1:0]` is set on the accept edge: bit0 = CPU read, bit1 = debug read. A CPU write sets nothing.
  - Next cycle: `cpu_rvalid`=`rd_owner[0]`, `dbg_rvalid`=`rd_owner[1]`.
  - `cpu_rdata` and `dbg_rdata` = `mem_rdata` when their rvalid is high, else 0.
- Writes produce no rvalid.

## Timing
- Grant latency: 0 cycles, combinational from `req`. CPU starvation bound is 0 extra cycles when uncontested.
- Debug starvation bound: a continuously asserted `dbg_req` is granted within `CPU_WEIGHT`+1 cycles.
- Read latency: data and `rvalid` appear exactly 1 cycle after the accept edge and last 1 cycle.
- Throughput: one access per cycle; a read and a following write to the same address are ordered by accept order.
- Reset values (async, `RESETn`=0): all outputs 0, `cpu_run`=0, `last`=0, `rd_owner`=0, mem shadow=0.
- Reset mid-operation: an outstanding read is dropped (no rvalid after release). The first post-reset cycle arbitrates fresh.
- Requester dropping `req` without a grant is tolerated: no access and no state change except the normal `cpu_run` rules.

## Test plan
- Reset: hold `RESETn`=0 with both reqs high. Required: all outputs 0. Release: CPU granted first.
- CPU only: write 0x5A to 0x030, then read 0x030. Required: `mem_we`=1 on the write. The read gives `cpu_rvalid`=1 with `cpu_rdata`=0x5A one cycle later and `dbg_rvalid`=0.
- Debug only: read 0x000..0x00F back-to-back. Required: 16 consecutive grants, each `dbg_rvalid` one cycle after, data in order.
- Contention, `CPU_WEIGHT`=4, both reqs held high for 20 cycles. Required grant pattern: C C C C D C C C C D …; never two D in a row; never both gnts.
- Debug write attempt: `dbg_req` high while `cpu_we`=1 and CPU idle. Required: `mem_we`=0 on the debug grant.
- Reset asserted the cycle after a CPU read accept. Required: no `cpu_rvalid`, and `cpu_run` and `last` return to 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM read/write port between the CPU and the debug dumper; grants are combinational from req.
// CPU wins contested cycles, at most CPU_WEIGHT in a row; read data returns one cycle after accept, tagged to its owner.
module bram_port_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 8,
  parameter int CPU_WEIGHT = 4
) (
  input  logic          clk,
  input  logic          RESETn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

  logic [3:0]    cpu_run_q, cpu_run_d;
  logic          last_q, last_d;
  logic [1:0]    rd_owner_q, rd_owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic contested;
  logic dbg_turn;
  logic cpu_win;
  logic dbg_win;

  // Ungated winners feed the state; only the visible grants are forced low during reset.
  always_comb begin
    contested = cpu_req & dbg_req;
    dbg_turn  = contested & (cpu_run_q == WEIGHT) & ~last_q;
    cpu_win   = cpu_req & ~dbg_turn;
    dbg_win   = dbg_req & ~cpu_win;
  end

  assign cpu_gnt = RESETn & cpu_win;
  assign dbg_gnt = RESETn & dbg_win;

  always_comb begin
    cpu_run_d = cpu_run_q;
    last_d    = last_q;
    if (cpu_win && contested) begin
      cpu_run_d = (cpu_run_q >= WEIGHT) ? WEIGHT : cpu_run_q + 4'd1;
    end else if (cpu_win || dbg_win) begin
      cpu_run_d = 4'd0;
    end
    if (cpu_win) begin
      last_d = 1'b0;
    end else if (dbg_win) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    rd_owner_d = {dbg_win, cpu_win & ~cpu_we};
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (cpu_win) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end else if (dbg_win) begin
      addr_d  = dbg_addr;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      cpu_run_q  <= 4'd0;
      last_q     <= 1'b0;
      rd_owner_q <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      cpu_run_q  <= cpu_run_d;
      last_q     <= last_d;
      rd_owner_q <= rd_owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Idle cycles replay the shadow so the RAM pins do not toggle.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (cpu_gnt) begin
      mem_ce    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_ce    = 1'b1;
      mem_addr  = dbg_addr;
      mem_wdata = '0;
    end
  end

  always_comb begin
    cpu_rvalid = rd_owner_q[0];
    dbg_rvalid = rd_owner_q[1];
    cpu_rdata  = rd_owner_q[0] ? mem_rdata : '0;
    dbg_rdata  = rd_owner_q[1] ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: RAM model, reference model compared every cycle, directed and random phases.
module tb_bram_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          RESETn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AW(AW), .DW(DW), .CPU_WEIGHT(W)) dut (
    .clk(clk), .RESETn(RESETn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] ram_init(input int a);
    return DW'((a * 37 + 11) & 8'hFF);
  endfunction

  // Synchronous RAM behind port B.
  logic [DW-1:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  // Reference model: arbitration from the weighting rule, memory as a plain array.
  logic [DW-1:0] ref_mem [0:2047];
  int            streak;
  bit            prev_dbg;
  int            pend;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] sh_addr;
  logic [DW-1:0] sh_wdata;
  int            dbg_wait;

  always @(negedge clk) begin
    bit            ecg, edg, both;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    if (!RESETn) begin
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_dbg_gnt", dbg_gnt, 0);
      check("rst_mem_ce", mem_ce, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_dbg_rvalid", dbg_rvalid, 0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 0);
      check("rst_dbg_rdata", 32'(dbg_rdata), 0);
      streak = 0; prev_dbg = 0; pend = 0; sh_addr = '0; sh_wdata = '0; dbg_wait = 0;
    end else begin
      both = cpu_req && dbg_req;
      ecg  = cpu_req && !(both && streak >= W && !prev_dbg);
      edg  = dbg_req && !ecg;
      e_addr  = ecg ? cpu_addr  : (edg ? dbg_addr : sh_addr);
      e_wdata = ecg ? cpu_wdata : (edg ? '0 : sh_wdata);
      check("cpu_gnt", cpu_gnt, 32'(ecg));
      check("dbg_gnt", dbg_gnt, 32'(edg));
      check("gnt_exclusive", cpu_gnt & dbg_gnt, 0);
      check("mem_ce", mem_ce, 32'(ecg || edg));
      check("mem_we", mem_we, 32'(ecg && cpu_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      check("cpu_rvalid", cpu_rvalid, 32'(pend == 1));
      check("dbg_rvalid", dbg_rvalid, 32'(pend == 2));
      check("cpu_rdata", 32'(cpu_rdata), (pend == 1) ? 32'(pend_data) : 0);
      check("dbg_rdata", 32'(dbg_rdata), (pend == 2) ? 32'(pend_data) : 0);
      if (edg) begin
        check("dbg_starvation", (dbg_wait <= W), 1);
        dbg_wait = 0;
      end else if (dbg_req) dbg_wait++;
      else dbg_wait = 0;
      pend = 0;
      if (ecg && !cpu_we) begin pend = 1; pend_data = ref_mem[cpu_addr]; end
      if (edg)            begin pend = 2; pend_data = ref_mem[dbg_addr]; end
      if (ecg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (both && ecg) streak = (streak + 1 > W) ? W : streak + 1;
      else if (ecg || edg) streak = 0;
      if (ecg || edg) prev_dbg = edg;
      sh_addr = e_addr; sh_wdata = e_wdata;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    bit gc, gd;
    int rst_cnt;
    for (int i = 0; i < 2048; i++) begin ram[i] = ram_init(i); ref_mem[i] = ram_init(i); end
    RESETn = 0; cpu_req = 1; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1; dbg_addr = '0; rst_cnt = 0;

    repeat (3) @(negedge clk);
    check("reset_held_gnt", {cpu_gnt, dbg_gnt}, 0);
    step(); RESETn = 1;
    @(negedge clk);
    check("release_cpu_first", cpu_gnt, 1);

    // CPU only: write 0x5A to 0x030, read it back.
    step(); dbg_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 11'h030; cpu_wdata = 8'h5A;
    @(negedge clk);
    check("cpu_write_we", mem_we, 1);
    step(); cpu_we = 0;
    @(negedge clk);
    check("cpu_read_gnt", cpu_gnt, 1);
    step(); cpu_req = 0;
    @(negedge clk);
    check("cpu_read_rvalid", cpu_rvalid, 1);
    check("cpu_read_data", 32'(cpu_rdata), 32'h5A);
    check("cpu_read_no_dbg", dbg_rvalid, 0);

    // Debug only: back-to-back reads 0x000..0x00F.
    for (int i = 0; i < 16; i++) begin
      step(); dbg_req = 1; dbg_addr = 11'(i);
      @(negedge clk);
      check("dbg_burst_gnt", dbg_gnt, 1);
      if (i > 0) begin
        check("dbg_burst_rvalid", dbg_rvalid, 1);
        check("dbg_burst_data", 32'(dbg_rdata), 32'(ram_init(i - 1)));
      end
    end
    step(); dbg_req = 0;
    @(negedge clk);
    check("dbg_burst_last", 32'(dbg_rdata), 32'(ram_init(15)));

    // Contention for 20 cycles.
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 11'h100; dbg_req = 1; dbg_addr = 11'h200;
    pat = "";
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pat = {pat, cpu_gnt ? "C" : (dbg_gnt ? "D" : "-")};
      step();
    end
    check_str("contention_pattern", pat, "CCCCDCCCCDCCCCDCCCCD");

    // Debug grant while CPU presents a write but is not requesting.
    cpu_req = 0; cpu_we = 1; dbg_req = 1; dbg_addr = 11'h030;
    @(negedge clk);
    check("dbg_grant_no_write", {dbg_gnt, mem_we}, 2'b10);

    // Reset right after a CPU read accept.
    step(); dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h030;
    step(); cpu_req = 0; RESETn = 0;
    @(negedge clk);
    check("reset_drops_rvalid", cpu_rvalid, 0);
    step(); step(); RESETn = 1; cpu_req = 1; dbg_req = 1;
    @(negedge clk);
    check("post_reset_no_rvalid", cpu_rvalid, 0);
    pat = "";
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      pat = {pat, cpu_gnt ? "C" : (dbg_gnt ? "D" : "-")};
      step();
    end
    check_str("post_reset_pattern", pat, "CCCCD");

    // Random traffic obeying the hold-until-grant handshake, with occasional drops and resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); gc = cpu_gnt; gd = dbg_gnt;
      step();
      if (!RESETn) begin
        if (rst_cnt == 0) RESETn = 1; else rst_cnt--;
      end else if ($urandom_range(0, 599) == 0) begin
        RESETn = 0; rst_cnt = 1;
      end
      if (gc || !cpu_req) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = ($urandom_range(0, 2) == 0);
        cpu_addr  = 11'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end else if ($urandom_range(0, 29) == 0) cpu_req = 0;
      if (gd || !dbg_req) begin
        dbg_req  = ($urandom_range(0, 2) != 0);
        dbg_addr = 11'($urandom_range(0, 31));
      end else if ($urandom_range(0, 29) == 0) dbg_req = 0;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
